pipe_add_sub: RTL
=================

PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits, N >= 2.
REQ-002 SHALL have parameter STAGES, default 2: pipeline segments, 1 <= STAGES <= N, N divisible by STAGES; chunk width W = N/STAGES.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: operands valid.
REQ-006 SHALL have port in_ready  output  1: block accepts operands this cycle.
REQ-007 SHALL have port a  input  N: operand A.
REQ-008 SHALL have port b  input  N: operand B.
REQ-009 SHALL have port cin  input  1: carry-in, add mode only.
REQ-010 SHALL have port sub  input  1: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1: result valid.
REQ-012 SHALL have port out_ready  input  1: consumer accepts result.
REQ-013 SHALL have port sum  output  N+1: result; sum[N] = carry-out (sub: 1 = no borrow).
REQ-014 SHALL have port ovf  output  1: two's-complement signed overflow of sum[N-1:0].

Function
REQ-015 Add: result = a + b + cin, N+1 bits. Sub: result = a + ~b + 1, cin ignored.
REQ-016 Stage k (0..STAGES-1) SHALL add chunk k, bits [kW+W-1:kW], with the carry registered from stage k-1; stage 0 uses the effective carry-in from REQ-015.
REQ-017 Unprocessed upper chunks, completed lower sum bits, carry and operand sign bits SHALL travel with each transaction through per-stage registers.
REQ-018 Each stage SHALL hold one valid bit; transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-019 Global advance = !out_valid || out_ready; in_ready SHALL equal advance, combinationally; all stages shift together when advance = 1, and hold otherwise.
REQ-020 Latency SHALL be exactly STAGES cycles from acceptance to out_valid with no backpressure; throughput one result per cycle.
REQ-021 Bubbles (in_valid = 0 while advancing) SHALL propagate as invalid stages; the block does not compact bubbles.
REQ-022 sum, ovf SHALL stay stable while out_valid && !out_ready.
REQ-023 ovf SHALL be (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]), where b_eff = b in add mode and ~b in sub mode.
REQ-024 Results SHALL be delivered in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-025 With STAGES = 1 the block SHALL reduce to a single registered N-bit adder with the same handshake.

Reset
REQ-026 When rst_n = 0 at a clock edge, all valid bits, sum and ovf SHALL become 0; data registers SHALL be cleared to 0.
REQ-027 out_valid SHALL be 0 in the cycle after any reset edge; in_ready SHALL be 1 out of reset.
REQ-028 Reset mid-operation SHALL discard all in-flight transactions; none emerges afterwards.

Structure
REQ-029 A shared package pipe_add_pkg SHALL hold the default N and STAGES constants and the add/sub mode encoding (MODE_ADD = 0, MODE_SUB = 1).
REQ-030 The chunk adder SHALL be the combinational sub-module rca_chunk (W-bit ripple adder: a, b, cin -> sum, cout), instantiated once per stage via generate.
REQ-031 No latches and no asynchronous reset; in_ready is the only combinational input-to-output path.

Verification (N=8, STAGES=2)
REQ-032 Reset: hold rst_n = 0 for 2 cycles -> out_valid = 0, sum = 9'h000, ovf = 0, in_ready = 1.
REQ-033 Add carry: a=8'hFF, b=8'h01, cin=0, sub=0, out_ready=1 -> 2 cycles later sum = 9'h100, ovf = 0.
REQ-034 Signed overflow: a=8'h7F, b=8'h01, add -> sum = 9'h080, ovf = 1. Subtract: a=8'h80, b=8'h01, sub=1 -> sum = 9'h17F, ovf = 1.
REQ-035 Backpressure: send 4 back-to-back adds (1+1, 2+2, 3+3, 4+4), out_ready = 0 once the first is valid -> in_ready = 0 while stalled. After release, outputs 2, 4, 6, 8 in order, no gaps, with sum held stable while stalled.
REQ-036 Reset mid-flight: 2 transactions accepted, rst_n = 0 for 1 cycle -> out_valid = 0 next cycle, and neither result ever appears.
REQ-037 Random: 10k random a, b, cin, sub values with random in_valid/out_ready -> every result matches the REQ-015/REQ-023 reference model, in order.

Source files
------------

// File: rtl/pipe_add_pkg.sv
// Shared constants and mode encoding for the pipelined add/subtract block.
package pipe_add_pkg;

  localparam int N_DEFAULT      = 8;
  localparam int STAGES_DEFAULT = 2;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Subtraction is a + ~b + 1, so the incoming carry is forced high in that mode.
  function automatic logic eff_carry(input mode_e mode, input logic cin);
    return (mode == MODE_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/pipe_add_sub_if.sv
// Operand/result bundle for pipe_add_sub; master is the producer/consumer side, slave the adder.
interface pipe_add_sub_if #(
  parameter int N = 8
) ();

  // Valid/ready: a beat transfers on a rising edge where valid && ready are both high;
  // valid never waits on ready, and ready may depend combinationally on the consumer.
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   sum;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, ovf
  );

endinterface

// File: rtl/rca_chunk.sv
// W-bit combinational ripple-carry adder used for one pipeline segment.
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined N-bit adder/subtractor: one W-bit chunk per stage, carry registered between stages.
module pipe_add_sub
  import pipe_add_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int STAGES = STAGES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   sum,
  output logic         ovf
);

  localparam int W = N / STAGES;

  // Boundary k is the input of stage k; boundary STAGES is the output register set.
  logic         v_b  [STAGES+1];
  logic [N-1:0] a_b  [STAGES+1];
  logic [N-1:0] b_b  [STAGES+1];
  logic [N-1:0] s_b  [STAGES+1];
  logic         c_b  [STAGES+1];
  logic         sa_b [STAGES+1];
  logic         sb_b [STAGES+1];

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign v_b[0]  = in_valid;
  assign a_b[0]  = a;
  assign b_b[0]  = (mode_e'(sub) == MODE_SUB) ? ~b : b;
  assign s_b[0]  = '0;
  assign c_b[0]  = eff_carry(mode_e'(sub), cin);
  assign sa_b[0] = a[N-1];
  assign sb_b[0] = b_b[0][N-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W-1:0] chunk_sum;
    logic         chunk_cout;
    logic         v_r;
    logic         c_r;
    logic         sa_r;
    logic         sb_r;
    logic [N-1:0] s_r;

    rca_chunk #(.W(W)) u_rca (
      .a    (a_b[k][k*W +: W]),
      .b    (b_b[k][k*W +: W]),
      .cin  (c_b[k]),
      .sum  (chunk_sum),
      .cout (chunk_cout)
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_r  <= 1'b0;
        c_r  <= 1'b0;
        sa_r <= 1'b0;
        sb_r <= 1'b0;
        s_r  <= '0;
      end else if (advance) begin
        v_r            <= v_b[k];
        c_r            <= chunk_cout;
        sa_r           <= sa_b[k];
        sb_r           <= sb_b[k];
        s_r            <= s_b[k];
        s_r[k*W +: W]  <= chunk_sum;
      end
    end

    assign v_b[k+1]  = v_r;
    assign c_b[k+1]  = c_r;
    assign sa_b[k+1] = sa_r;
    assign sb_b[k+1] = sb_r;
    assign s_b[k+1]  = s_r;

    // Operands only need to travel while upper chunks remain to be added.
    if (k < STAGES - 1) begin : g_fwd
      logic [N-1:0] a_r;
      logic [N-1:0] b_r;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (advance) begin
          a_r <= a_b[k];
          b_r <= b_b[k];
        end
      end

      assign a_b[k+1] = a_r;
      assign b_b[k+1] = b_r;
    end else begin : g_last
      assign a_b[k+1] = '0;
      assign b_b[k+1] = '0;
    end
  end

  assign out_valid = v_b[STAGES];
  assign sum       = {c_b[STAGES], s_b[STAGES]};
  assign ovf       = (sa_b[STAGES] == sb_b[STAGES]) && (s_b[STAGES][N-1] != sa_b[STAGES]);

endmodule
